// File: rtl/agc_sequencer_pkg.sv
// Shared definitions for the AGC sequencer: FSM state encoding, channel
// index constants and the count widths derived from the window size.
package agc_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        UPDATE  = 3'd3,
        NEXT    = 3'd4
    } agc_state_e;

    localparam logic [1:0] CH0        = 2'd0;
    localparam logic [1:0] CH1        = 2'd1;
    localparam logic [1:0] CH2        = 2'd2;
    localparam logic [1:0] CH_INVALID = 2'd3;

    // Raw accumulator: the full-scale count 2^(W+1) needs one extra bit.
    function automatic int count_w(input int window_log2);
        return window_log2 + 2;
    endfunction

    // Latched count, saturated to all-ones at full scale.
    function automatic int latch_w(input int window_log2);
        return window_log2 + 1;
    endfunction

endpackage

// File: rtl/agc_sequencer_if.sv
// Control/status bundle between the housekeeping side (master) and the
// AGC sequencer (slave): loop controls, quantizer magnitudes, CPU gain
// override, and the per-channel gain words and loop status.
interface agc_sequencer_if #(
    parameter int NCH         = 3,
    parameter int PWM_W       = 10,
    parameter int WINDOW_LOG2 = 12
) ();
    import agc_sequencer_pkg::*;

    localparam int LAT_W = latch_w(WINDOW_LOG2);

    logic                   enable;
    logic                   sample_en;
    logic [2*NCH-1:0]       mag;
    logic [LAT_W-1:0]       target;
    logic [7:0]             deadband;
    logic                   cpu_wr;
    logic [1:0]             cpu_ch;
    logic [PWM_W-1:0]       cpu_gain;
    logic                   clear_flags;

    logic [NCH*PWM_W-1:0]   gain;
    logic [1:0]             cur_ch;
    logic                   busy;
    logic                   update;
    logic [LAT_W-1:0]       last_count;
    logic [NCH-1:0]         sat_flags;

    modport master (
        output enable, sample_en, mag, target, deadband,
               cpu_wr, cpu_ch, cpu_gain, clear_flags,
        input  gain, cur_ch, busy, update, last_count, sat_flags
    );

    modport slave (
        input  enable, sample_en, mag, target, deadband,
               cpu_wr, cpu_ch, cpu_gain, clear_flags,
        output gain, cur_ch, busy, update, last_count, sat_flags
    );

endinterface

// File: rtl/agc_gain_step.sv
// Combinational loop decision: compares a window count against the
// inclusive band [target-deadband, target+deadband] and steps the gain up
// or down by STEP, clamping at the limits. o_sat flags a step that was
// requested while the gain already sat at the relevant limit.
module agc_gain_step #(
    parameter int               PWM_W    = 10,
    parameter int               LAT_W    = 13,
    parameter int               STEP     = 4,
    parameter logic [PWM_W-1:0] GAIN_MAX = '1,
    parameter logic [PWM_W-1:0] GAIN_MIN = '0
) (
    input  logic [PWM_W-1:0] i_gain,
    input  logic [LAT_W-1:0] i_count,
    input  logic [LAT_W-1:0] i_target,
    input  logic [7:0]       i_deadband,
    output logic [PWM_W-1:0] o_gain,
    output logic             o_sat
);

    // One bit wider than the widest operand so target+deadband never wraps.
    localparam int BND_W = ((LAT_W > 8) ? LAT_W : 8) + 1;
    localparam logic [PWM_W:0] STEP_EXT = (PWM_W+1)'(STEP);

    logic [BND_W-1:0] w_target;
    logic [BND_W-1:0] w_deadband;
    logic [BND_W-1:0] w_count;
    logic [BND_W-1:0] w_lo;
    logic [BND_W-1:0] w_hi;
    logic [PWM_W:0]   w_gain_ext;
    logic             w_inc;
    logic             w_dec;

    assign w_target   = BND_W'(i_target);
    assign w_deadband = BND_W'(i_deadband);
    assign w_count    = BND_W'(i_count);
    assign w_lo       = (w_target > w_deadband) ? (w_target - w_deadband) : '0;
    assign w_hi       = w_target + w_deadband;
    assign w_inc      = (w_count < w_lo);
    assign w_dec      = (w_count > w_hi);
    assign w_gain_ext = {1'b0, i_gain};

    // Clamped step in the requested direction, plus saturation indication.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_gain = i_gain;
        o_sat  = 1'b0;
        if (w_inc) begin
            o_sat = (i_gain == GAIN_MAX);
            if (w_gain_ext + STEP_EXT > {1'b0, GAIN_MAX}) begin
                o_gain = GAIN_MAX;
            end else begin
                o_gain = i_gain + PWM_W'(STEP);
            end
        end else if (w_dec) begin
            o_sat = (i_gain == GAIN_MIN);
            if (w_gain_ext < STEP_EXT + {1'b0, GAIN_MIN}) begin
                o_gain = GAIN_MIN;
            end else begin
                o_gain = i_gain - PWM_W'(STEP);
            end
        end
    end

endmodule

// File: rtl/agc_sequencer.sv
// Round-robin AGC sequencer: one measurement engine time-shared across the
// channels. Per channel it settles, counts high-magnitude samples over a
// window, then steps that channel's gain word toward the target band.
// Optional sticky saturation flags are built when AGC_SAT_FLAGS_EN is
// defined; otherwise sat_flags is tied to zero.
module agc_sequencer
    import agc_sequencer_pkg::*;
#(
    parameter int NCH         = 3,
    parameter int PWM_W       = 10,
    parameter int WINDOW_LOG2 = 12,
    parameter int SETTLE_LOG2 = 10,
    parameter int STEP        = 4,
    parameter int GAIN_INIT   = 512
) (
    input  logic           clk,
    input  logic           reset_n,
    agc_sequencer_if.slave agc
);

    localparam int CNT_W = count_w(WINDOW_LOG2);
    localparam int LAT_W = latch_w(WINDOW_LOG2);

    agc_state_e              r_state;
    agc_state_e              w_state_next;
    logic [SETTLE_LOG2-1:0]  r_settle_cnt;
    logic [WINDOW_LOG2-1:0]  r_sample_cnt;
    logic [CNT_W-1:0]        r_acc;
    logic [1:0]              r_cur_ch;
    logic [LAT_W-1:0]        r_last_count;
    logic [PWM_W-1:0]        r_gain [NCH];

    logic                    w_settle_done;
    logic                    w_window_done;
    logic [2:0]              w_mag_lsb;
    logic [1:0]              w_mag_pair;
    logic [CNT_W-1:0]        w_add;
    logic [LAT_W-1:0]        w_count_sat;
    logic [PWM_W-1:0]        w_cur_gain;
    logic [PWM_W-1:0]        w_step_gain;
    logic                    w_step_sat;
    logic                    w_do_update;
    logic                    w_cpu_hit;

    assign w_settle_done = &r_settle_cnt;
    assign w_window_done = (&r_sample_cnt) && agc.sample_en;
    assign w_mag_lsb     = {r_cur_ch, 1'b0};
    assign w_mag_pair    = agc.mag[w_mag_lsb +: 2];
    assign w_add         = CNT_W'(w_mag_pair[0]) + CNT_W'(w_mag_pair[1]);
    // Only the full-scale count sets the top bit; clamp it to all-ones.
    assign w_count_sat   = r_acc[CNT_W-1] ? '1 : r_acc[LAT_W-1:0];
    assign w_do_update   = (r_state == UPDATE) && agc.enable;
    assign w_cpu_hit     = agc.cpu_wr && (int'(agc.cpu_ch) < NCH);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and status outputs; dropping enable aborts to IDLE.
    always_comb begin
        w_state_next = r_state;
        agc.busy     = (r_state != IDLE);
        agc.update   = w_do_update;
        case (r_state)
            IDLE:    if (agc.enable)    w_state_next = SETTLE;
            SETTLE:  if (w_settle_done) w_state_next = MEASURE;
            MEASURE: if (w_window_done) w_state_next = UPDATE;
            UPDATE:  w_state_next = NEXT;
            NEXT:    w_state_next = SETTLE;
            default: w_state_next = IDLE;
        endcase
        if (!agc.enable) begin
            w_state_next = IDLE;
        end
    end

    // Settle/sample counters, accumulator, channel pointer, latched count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_settle_cnt <= '0;
            r_sample_cnt <= '0;
            r_acc        <= '0;
            r_cur_ch     <= CH0;
            r_last_count <= '0;
        end else begin
            r_settle_cnt <= (r_state == SETTLE && agc.enable) ? r_settle_cnt + 1'b1 : '0;
            // Holding the accumulator clear through SETTLE discards any
            // partial count left by an aborted window.
            if (r_state == SETTLE) begin
                r_acc        <= '0;
                r_sample_cnt <= '0;
            end else if (r_state == MEASURE && agc.enable && agc.sample_en) begin
                r_acc        <= r_acc + w_add;
                r_sample_cnt <= r_sample_cnt + 1'b1;
            end
            if (!agc.enable) begin
                r_cur_ch <= CH0;
            end else if (r_state == NEXT) begin
                r_cur_ch <= (r_cur_ch == 2'(NCH-1)) ? CH0 : r_cur_ch + 2'd1;
            end
            if (w_do_update) begin
                r_last_count <= w_count_sat;
            end
        end
    end

    // Select the scheduled channel's gain for the shared step unit.
    always_comb begin
        w_cur_gain = r_gain[0];
        for (int k = 0; k < NCH; k++) begin
            if (int'(r_cur_ch) == k) begin
                w_cur_gain = r_gain[k];
            end
        end
    end

    agc_gain_step #(
        .PWM_W    (PWM_W),
        .LAT_W    (LAT_W),
        .STEP     (STEP),
        .GAIN_MAX ({PWM_W{1'b1}}),
        .GAIN_MIN ({PWM_W{1'b0}})
    ) u_gain_step (
        .i_gain     (w_cur_gain),
        .i_count    (w_count_sat),
        .i_target   (agc.target),
        .i_deadband (agc.deadband),
        .o_gain     (w_step_gain),
        .o_sat      (w_step_sat)
    );

    // Gain words: a CPU write to a channel overrides that channel's step.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            // NOTE: the gain array is a handful of registers with a defined power-up value, so it is reset explicitly.
            if (!reset_n) begin
                r_gain[k] <= PWM_W'(GAIN_INIT);
            end else if (w_cpu_hit && int'(agc.cpu_ch) == k) begin
                r_gain[k] <= agc.cpu_gain;
            end else if (w_do_update && int'(r_cur_ch) == k) begin
                r_gain[k] <= w_step_gain;
            end
        end
    end

    // Pack gain words onto the flat output bus.
    always_comb begin
        agc.gain = '0;
        for (int k = 0; k < NCH; k++) begin
            agc.gain[k*PWM_W +: PWM_W] = r_gain[k];
        end
    end

    assign agc.cur_ch     = r_cur_ch;
    assign agc.last_count = r_last_count;

`ifdef AGC_SAT_FLAGS_EN
    logic [NCH-1:0] r_sat_flags;

    // Sticky saturation flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sat_flags <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (w_do_update && int'(r_cur_ch) == k && w_step_sat) begin
                    r_sat_flags[k] <= 1'b1;
                end else if (agc.clear_flags) begin
                    r_sat_flags[k] <= 1'b0;
                end
            end
        end
    end

    assign agc.sat_flags = r_sat_flags;
`else
    logic w_unused_sat;
    assign w_unused_sat  = w_step_sat ^ agc.clear_flags;
    assign agc.sat_flags = '0;
`endif

endmodule

// File: tb/tb_agc_sequencer.sv
// Self-checking bench for agc_sequencer with a short window (16 samples)
// and settle (4 cycles), target 8, deadband 2 (band 6..10 inclusive).
// A vector table covers steady-state loop steps; hand-written sequences
// cover band edges, saturation, CPU override and abort/reset.
module tb_agc_sequencer;

    localparam int NCH   = 3;
    localparam int PWM_W = 10;
    localparam int WL2   = 4;
    localparam int SL2   = 2;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    agc_sequencer_if #(.NCH(NCH), .PWM_W(PWM_W), .WINDOW_LOG2(WL2)) agc_if ();

    agc_sequencer #(
        .NCH         (NCH),
        .PWM_W       (PWM_W),
        .WINDOW_LOG2 (WL2),
        .SETTLE_LOG2 (SL2),
        .STEP        (4),
        .GAIN_INIT   (512)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .agc     (agc_if)
    );

    typedef struct {
        bit         rst;
        logic [5:0] mag;
        int         ch;
        int         g0;
        int         g1;
        int         g2;
        int         cnt;
    } vec_t;

    vec_t vecs [9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int gain_of(input int k);
        logic [NCH*PWM_W-1:0] g;
        g = agc_if.gain;
        return int'(g[k*PWM_W +: PWM_W]);
    endfunction

    // Reset with the loop stopped, then release and enable it.
    task automatic do_reset();
        reset_n            = 1'b0;
        agc_if.enable      = 1'b0;
        agc_if.cpu_wr      = 1'b0;
        agc_if.clear_flags = 1'b0;
        agc_if.mag         = '0;
        tick();
        tick();
        reset_n       = 1'b1;
        agc_if.enable = 1'b1;
    endtask

    // Wait (bounded) until the update pulse is visible; stays in that cycle.
    task automatic wait_upd(input string name);
        int n;
        n = 0;
        while (agc_if.update !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check({name, " update_seen"}, int'(agc_if.update === 1'b1), 1);
    endtask

    // Step through one update cycle so the next wait finds the next pulse.
    task automatic pass_upd(input string name);
        wait_upd(name);
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sat_exp;
        logic seen;

        n_tests = 0;
        n_fail  = 0;
        reset_n            = 1'b0;
        agc_if.enable      = 1'b0;
        agc_if.sample_en   = 1'b1;
        agc_if.mag         = '0;
        agc_if.target      = 5'd8;
        agc_if.deadband    = 8'd2;
        agc_if.cpu_wr      = 1'b0;
        agc_if.cpu_ch      = 2'd0;
        agc_if.cpu_gain    = '0;
        agc_if.clear_flags = 1'b0;

`ifdef AGC_SAT_FLAGS_EN
        sat_exp = 1;
`else
        sat_exp = 0;
`endif

        //            rst   mag        ch  g0   g1   g2   cnt
        vecs[0] = '{1'b1, 6'b000000, 0, 516, 512, 512, 0};
        vecs[1] = '{1'b0, 6'b000000, 1, 516, 516, 512, 0};
        vecs[2] = '{1'b0, 6'b000000, 2, 516, 516, 516, 0};
        vecs[3] = '{1'b0, 6'b000000, 0, 520, 516, 516, 0};
        vecs[4] = '{1'b1, 6'b111111, 0, 508, 512, 512, 31};
        vecs[5] = '{1'b0, 6'b111111, 1, 508, 508, 512, 31};
        vecs[6] = '{1'b0, 6'b111111, 2, 508, 508, 508, 31};
        vecs[7] = '{1'b0, 6'b000100, 0, 512, 508, 508, 0};
        vecs[8] = '{1'b0, 6'b000100, 1, 512, 504, 508, 16};

        // Reset state.
        tick();
        tick();
        check("rst gain0", gain_of(0), 512);
        check("rst gain1", gain_of(1), 512);
        check("rst gain2", gain_of(2), 512);
        check("rst cur_ch", int'(agc_if.cur_ch), 0);
        check("rst busy", int'(agc_if.busy), 0);
        check("rst update", int'(agc_if.update), 0);
        check("rst last_count", int'(agc_if.last_count), 0);
        check("rst sat_flags", int'(agc_if.sat_flags), 0);

        // Table-driven loop steps.
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst) do_reset();
            agc_if.mag = vecs[i].mag;
            wait_upd($sformatf("v%0d", i));
            check($sformatf("v%0d cur_ch", i), int'(agc_if.cur_ch), vecs[i].ch);
            tick();
            check($sformatf("v%0d update_low", i), int'(agc_if.update), 0);
            check($sformatf("v%0d gain0", i), gain_of(0), vecs[i].g0);
            check($sformatf("v%0d gain1", i), gain_of(1), vecs[i].g1);
            check($sformatf("v%0d gain2", i), gain_of(2), vecs[i].g2);
            check($sformatf("v%0d last_count", i), int'(agc_if.last_count), vecs[i].cnt);
        end

        // Upper band edge: exactly 10 high samples inside ch0's window.
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        agc_if.mag = 6'b000001;
        for (int i = 0; i < 10; i++) tick();
        agc_if.mag = 6'b000000;
        pass_upd("edge10");
        check("edge10 last_count", int'(agc_if.last_count), 10);
        check("edge10 gain0", gain_of(0), 512);

        // Lower band edge: exactly 6 high samples.
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        agc_if.mag = 6'b000010;
        for (int i = 0; i < 6; i++) tick();
        agc_if.mag = 6'b000000;
        pass_upd("edge6");
        check("edge6 last_count", int'(agc_if.last_count), 6);
        check("edge6 gain0", gain_of(0), 512);

        // CPU write near the top, then clamp and saturation flag.
        do_reset();
        agc_if.cpu_wr   = 1'b1;
        agc_if.cpu_ch   = 2'd0;
        agc_if.cpu_gain = 10'd1021;
        tick();
        agc_if.cpu_wr = 1'b0;
        check("cpu gain0", gain_of(0), 1021);
        pass_upd("sat1");
        check("sat1 gain0", gain_of(0), 1023);
        check("sat1 flags", int'(agc_if.sat_flags), 0);
        pass_upd("sat_ch1");
        pass_upd("sat_ch2");
        pass_upd("sat2");
        check("sat2 gain0", gain_of(0), 1023);
        check("sat2 flags", int'(agc_if.sat_flags), sat_exp);
        agc_if.clear_flags = 1'b1;
        tick();
        agc_if.clear_flags = 1'b0;
        check("sat clear", int'(agc_if.sat_flags), 0);

        // CPU write coinciding with ch1's update: CPU value wins.
        do_reset();
        pass_upd("coll_ch0");
        wait_upd("coll");
        check("coll cur_ch", int'(agc_if.cur_ch), 1);
        agc_if.cpu_wr   = 1'b1;
        agc_if.cpu_ch   = 2'd1;
        agc_if.cpu_gain = 10'd100;
        tick();
        agc_if.cpu_wr = 1'b0;
        check("coll gain1", gain_of(1), 100);
        check("coll gain0", gain_of(0), 516);
        check("coll last_count", int'(agc_if.last_count), 0);

        // Ignored CPU channel 3 leaves all gains alone.
        agc_if.cpu_wr   = 1'b1;
        agc_if.cpu_ch   = 2'd3;
        agc_if.cpu_gain = 10'd7;
        tick();
        agc_if.cpu_wr = 1'b0;
        check("cpu ch3 gain0", gain_of(0), 516);
        check("cpu ch3 gain1", gain_of(1), 100);
        check("cpu ch3 gain2", gain_of(2), 512);

        // Abort mid-MEASURE on ch1, then reset mid-SETTLE.
        do_reset();
        pass_upd("abort_ch0");
        for (int i = 0; i < 10; i++) tick();
        check("abort pre cur_ch", int'(agc_if.cur_ch), 1);
        check("abort pre busy", int'(agc_if.busy), 1);
        agc_if.enable = 1'b0;
        tick();
        check("abort busy", int'(agc_if.busy), 0);
        check("abort cur_ch", int'(agc_if.cur_ch), 0);
        check("abort gain0", gain_of(0), 516);
        check("abort gain1", gain_of(1), 512);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (agc_if.update === 1'b1) seen = 1'b1;
            tick();
        end
        check("abort no update", int'(seen), 0);
        agc_if.enable = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("settle busy", int'(agc_if.busy), 1);
        reset_n = 1'b0;
        tick();
        check("midrst busy", int'(agc_if.busy), 0);
        check("midrst update", int'(agc_if.update), 0);
        check("midrst gain0", gain_of(0), 512);
        check("midrst cur_ch", int'(agc_if.cur_ch), 0);
        reset_n = 1'b1;
        wait_upd("restart");
        check("restart cur_ch", int'(agc_if.cur_ch), 0);
        tick();
        check("restart gain0", gain_of(0), 516);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
